// File: rtl/noc_router_xy.sv
// noc_router_xy: five-port XY mesh router with per-input FIFOs, per-output
// round-robin arbitration and credit-based flow control.
//
// Handshake: a flit moves on a link in any cycle where valid is high; there is
// no ready. The sender may only drive valid while it holds a credit for the
// receiver's buffer, and the receiver returns one credit as a single-cycle
// incr pulse for every flit it removes from that buffer.
module noc_router_xy #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] data_i,
    input  logic [4:0]          valid_i,
    input  logic [4:0]          incr_i,
    output logic [5*FLIT_W-1:0] data_o,
    output logic [4:0]          valid_o,
    output logic [4:0]          incr_o,
    output logic                err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]   MY_XV = X_W'(MY_X);
    localparam logic [Y_W-1:0]   MY_YV = Y_W'(MY_Y);

    // Input FIFO storage and bookkeeping, one FIFO per input port
    logic [FLIT_W-1:0] mem [5][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [5];
    logic [PTR_W-1:0]  wr_ptr [5];
    logic [CNT_W-1:0]  count  [5];

    // Per-output credit counters and round-robin pointers
    logic [CNT_W-1:0]  credit [5];
    logic [2:0]        rr     [5];

    // Combinational datapath
    logic [FLIT_W-1:0] head [5];
    logic [4:0]        req  [5];   // req[i][o]: input i wants output o
    logic [4:0]        gnt_valid;
    logic [2:0]        gnt_src [5];
    logic [4:0]        pop;
    logic [4:0]        wr_ok;
    logic [4:0]        cred_err;
    logic              err_set;

    // One-hot output selection for a flit using dimension-ordered XY routing
    function automatic logic [4:0] route_onehot(input logic [FLIT_W-1:0] f);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = f[FLIT_W-1 -: X_W];
        dy = f[FLIT_W-1-X_W -: Y_W];
        if (dx > MY_XV)      route_onehot = 5'b00100;  // E
        else if (dx < MY_XV) route_onehot = 5'b01000;  // W
        else if (dy > MY_YV) route_onehot = 5'b00001;  // N
        else if (dy < MY_YV) route_onehot = 5'b00010;  // S
        else                 route_onehot = 5'b10000;  // L
    endfunction

    // Reduce a port index in 0..8 back into 0..4
    function automatic logic [2:0] wrap5(input int v);
        wrap5 = (v >= 5) ? 3'(v - 5) : 3'(v);
    endfunction

    // Expose each FIFO head and the output it requests
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            head[i] = mem[i][rd_ptr[i]];
            req[i]  = (count[i] != '0) ? route_onehot(head[i]) : 5'b00000;
        end
    end

    // Round-robin arbitration per output, gated by credit availability
    always_comb begin
        for (int o = 0; o < 5; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_src[o]   = 3'd0;
            if (credit[o] != '0) begin
                for (int k = 0; k < 5; k++) begin
                    if (!gnt_valid[o] && req[wrap5(int'(rr[o]) + k)][o]) begin
                        gnt_valid[o] = 1'b1;
                        gnt_src[o]   = wrap5(int'(rr[o]) + k);
                    end
                end
            end
        end
    end

    // Each granted input pops its head; one head can only win one output
    always_comb begin
        pop = 5'b00000;
        for (int o = 0; o < 5; o++) begin
            if (gnt_valid[o]) pop[gnt_src[o]] = 1'b1;
        end
    end

    // Write acceptance: a full FIFO still accepts when it pops the same cycle
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            wr_ok[p] = valid_i[p] && ((count[p] != FULL) || pop[p]);
        end
    end

    // Credit overflow: a return arrives with the counter already at DEPTH
    always_comb begin
        for (int o = 0; o < 5; o++) begin
            cred_err[o] = incr_i[o] && !gnt_valid[o] && (credit[o] == FULL);
        end
        err_set = (|(valid_i & ~wr_ok)) || (|cred_err);
    end

    // FIFO storage writes; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (wr_ok[p]) mem[p][wr_ptr[p]] <= data_i[p*FLIT_W +: FLIT_W];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (wr_ok[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (pop[p])   rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                count[p] <= count[p] + CNT_W'(wr_ok[p]) - CNT_W'(pop[p]);
            end
        end
    end

    // Credit counters: a send and a return in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < 5; o++) credit[o] <= FULL;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (gnt_valid[o] && !incr_i[o])
                    credit[o] <= credit[o] - CNT_W'(1);
                else if (!gnt_valid[o] && incr_i[o] && (credit[o] != FULL))
                    credit[o] <= credit[o] + CNT_W'(1);
            end
        end
    end

    // Round-robin pointers move past the winner only when a grant happens
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < 5; o++) rr[o] <= 3'd0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (gnt_valid[o])
                    rr[o] <= (gnt_src[o] == 3'd4) ? 3'd0 : gnt_src[o] + 3'd1;
            end
        end
    end

    // Registered outputs: flit, valid, upstream credit return and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 5'b00000;
            incr_o  <= 5'b00000;
            err_o   <= 1'b0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (gnt_valid[o]) data_o[o*FLIT_W +: FLIT_W] <= head[gnt_src[o]];
            end
            valid_o <= gnt_valid;
            incr_o  <= pop;
            if (err_set) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_router_xy.sv
// Testbench for noc_router_xy at tile (1,1), DEPTH=4, 16-bit flits.
module tb_noc_router_xy;

    localparam int FLIT_W = 16;
    localparam int DEPTH  = 4;
    localparam int MY_X   = 1;
    localparam int MY_Y   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] data_i;
    logic [4:0]  valid_i;
    logic [4:0]  incr_i;
    logic [79:0] data_o;
    logic [4:0]  valid_o;
    logic [4:0]  incr_o;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: queues per input, credits and rr per output
    logic [15:0] mq [5][$];
    int          m_cred [5];
    int          m_rr   [5];
    logic [4:0]  exp_valid;
    logic [4:0]  exp_incr;
    logic        exp_err;
    logic [79:0] exp_data;

    noc_router_xy #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .X_W(2), .Y_W(2), .MY_X(MY_X), .MY_Y(MY_Y)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .incr_i(incr_i),
        .data_o(data_o), .valid_o(valid_o), .incr_o(incr_o), .err_o(err_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // XY route from the rules: 0=N 1=S 2=E 3=W 4=L
    function automatic int route_ref(input logic [15:0] f);
        int dx;
        int dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > MY_X) return 2;
        if (dx < MY_X) return 3;
        if (dy > MY_Y) return 0;
        if (dy < MY_Y) return 1;
        return 4;
    endfunction

    function automatic logic [79:0] lane_mask(input logic [4:0] v);
        logic [79:0] m;
        m = '0;
        for (int p = 0; p < 5; p++) if (v[p]) m[p*16 +: 16] = 16'hffff;
        return m;
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge
    task automatic tick(input logic [4:0] v, input logic [79:0] d,
                        input logic [4:0] inc, input logic r);
        int won [5];
        int i;
        valid_i = v;
        data_i  = d;
        incr_i  = inc;
        rst     = r;
        if (r) begin
            for (int p = 0; p < 5; p++) begin
                mq[p].delete();
                m_cred[p] = DEPTH;
                m_rr[p]   = 0;
            end
            exp_valid = '0;
            exp_incr  = '0;
            exp_err   = 1'b0;
            exp_data  = '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                won[o] = -1;
                if (m_cred[o] > 0) begin
                    for (int k = 0; k < 5; k++) begin
                        i = (m_rr[o] + k) % 5;
                        if (won[o] < 0 && mq[i].size() > 0 && route_ref(mq[i][0]) == o) won[o] = i;
                    end
                end
            end
            exp_valid = '0;
            exp_incr  = '0;
            for (int o = 0; o < 5; o++) begin
                if (won[o] >= 0) begin
                    exp_valid[o] = 1'b1;
                    exp_data[o*16 +: 16] = mq[won[o]][0];
                    exp_incr[won[o]] = 1'b1;
                    m_rr[o] = (won[o] + 1) % 5;
                end
            end
            for (int p = 0; p < 5; p++) if (exp_incr[p]) void'(mq[p].pop_front());
            for (int p = 0; p < 5; p++) begin
                if (v[p]) begin
                    if (mq[p].size() < DEPTH) mq[p].push_back(d[p*16 +: 16]);
                    else exp_err = 1'b1;
                end
            end
            for (int o = 0; o < 5; o++) begin
                if (exp_valid[o] && !inc[o]) m_cred[o]--;
                else if (!exp_valid[o] && inc[o]) begin
                    if (m_cred[o] == DEPTH) exp_err = 1'b1;
                    else m_cred[o]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick('0, '0, '0, 1'b1);
        tick('0, '0, '0, 1'b1);
        vectors++;
        if (valid_o !== 5'b0 || incr_o !== 5'b0 || err_o !== 1'b0 || data_o !== 80'b0) begin
            miscompares++;
            $display("FAIL reset: valid_o=%b incr_o=%b err_o=%b data_o=%h, want all zero",
                     valid_o, incr_o, err_o, data_o);
        end
    endtask

    task automatic test_single_route();
        logic [79:0] d;
        tick('0, '0, '0, 1'b1);
        d = {16'h8abc, 64'h0};
        for (int c = 0; c < 5; c++) begin
            tick((c == 0) ? 5'b10000 : 5'b00000, d, '0, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL single c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (c == 1) begin
                vectors++;
                if (valid_o !== 5'b00100 || incr_o !== 5'b10000 || data_o[47:32] !== 16'h8abc) begin
                    miscompares++;
                    $display("FAIL single_latency: valid_o=%b incr_o=%b dataE=%h, want 00100 10000 8abc",
                             valid_o, incr_o, data_o[47:32]);
                end
            end
        end
    endtask

    task automatic test_local_arbitration();
        logic [79:0] d;
        int order [$];
        int want [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
        tick('0, '0, '0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            d = '0;
            d[15:0]  = {4'h5, 12'(16 * c + 0)};
            d[31:16] = {4'h5, 12'(16 * c + 1)};
            d[63:48] = {4'h5, 12'(16 * c + 3)};
            tick((c < 3) ? 5'b01011 : 5'b00000, d, exp_valid & 5'b10000, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL arbitration c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (valid_o[4]) for (int p = 0; p < 5; p++) if (incr_o[p]) order.push_back(p);
        end
        vectors++;
        if (order.size() != 9) begin
            miscompares++;
            $display("FAIL arbitration_count: got %0d grants, want 9", order.size());
        end else begin
            for (int n = 0; n < 9; n++) begin
                vectors++;
                if (order[n] != want[n]) begin
                    miscompares++;
                    $display("FAIL arbitration_order[%0d]: got input %0d, want %0d", n, order[n], want[n]);
                end
            end
        end
    endtask

    task automatic test_credit_stall();
        logic [79:0] d;
        int sent;
        int after;
        tick('0, '0, '0, 1'b1);
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            d = {4'h8, 12'(c), 64'h0};
            tick((c < 6) ? 5'b10000 : 5'b00000, d, '0, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL stall c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (valid_o[2]) sent++;
        end
        vectors++;
        if (sent != 4) begin
            miscompares++;
            $display("FAIL stall_count: got %0d E flits, want 4", sent);
        end
        after = 0;
        for (int c = 0; c < 6; c++) begin
            tick('0, '0, (c == 0) ? 5'b00100 : 5'b00000, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL stall_resume c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (valid_o[2]) after++;
            if (c == 1) begin
                vectors++;
                if (valid_o[2] !== 1'b1 || data_o[47:32] !== 16'h8004) begin
                    miscompares++;
                    $display("FAIL stall_resume_latency: valid_o[E]=%b dataE=%h, want 1 8004",
                             valid_o[2], data_o[47:32]);
                end
            end
        end
        vectors++;
        if (after != 1) begin
            miscompares++;
            $display("FAIL stall_resume_count: got %0d E flits, want 1", after);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [79:0] d;
        int got;
        tick('0, '0, '0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            d = '0;
            d[79:64] = {4'h6, 12'(c)};
            d[15:0]  = {4'h6, 12'(256 + c - 7)};
            tick((c < 4) ? 5'b10000 : ((c >= 7 && c < 12) ? 5'b00001 : 5'b00000), d, '0, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL overflow c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
        end
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_err: err_o=%b, want 1", err_o);
        end
        got = 0;
        for (int c = 0; c < 12; c++) begin
            tick('0, '0, (c < 4) ? 5'b00001 : 5'b00000, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL overflow_drain c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (incr_o[0]) got++;
        end
        vectors++;
        if (got != 4 || err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drain_count: got %0d flits err_o=%b, want 4 and 1", got, err_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [79:0] d;
        int sent;
        tick('0, '0, '0, 1'b1);
        d = '0;
        d[15:0]  = 16'h5001;
        d[31:16] = 16'h5002;
        d[47:32] = 16'h5003;
        tick(5'b00111, d, '0, 1'b0);
        tick('0, '0, '0, 1'b1);
        vectors++;
        if (valid_o !== 5'b0 || incr_o !== 5'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: valid_o=%b incr_o=%b err_o=%b, want 0 0 0", valid_o, incr_o, err_o);
        end
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            d = {4'h4, 12'(c), 64'h0};
            tick((c >= 3 && c < 9) ? 5'b10000 : 5'b00000, d, '0, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (valid_o[1]) sent++;
            if (c == 4) begin
                vectors++;
                if (valid_o !== 5'b00010 || incr_o !== 5'b10000 || data_o[31:16] !== 16'h4003) begin
                    miscompares++;
                    $display("FAIL reset_mid_latency: valid_o=%b incr_o=%b dataS=%h, want 00010 10000 4003",
                             valid_o, incr_o, data_o[31:16]);
                end
            end
        end
        vectors++;
        if (sent != DEPTH) begin
            miscompares++;
            $display("FAIL reset_mid_credits: got %0d S flits, want %0d", sent, DEPTH);
        end
    endtask

    task automatic test_credit_overflow();
        logic [79:0] d;
        int sent;
        tick('0, '0, '0, 1'b1);
        tick('0, '0, 5'b01000, 1'b0);
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_overflow_err: err_o=%b, want 1", err_o);
        end
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            d = {4'h1, 12'(c), 64'h0};
            tick((c < 6) ? 5'b10000 : 5'b00000, d, '0, 1'b0);
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL credit_overflow c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
            if (valid_o[3]) sent++;
        end
        vectors++;
        if (sent != 4) begin
            miscompares++;
            $display("FAIL credit_overflow_count: got %0d W flits, want 4", sent);
        end
    endtask

    task automatic test_random();
        logic [79:0] d;
        logic [4:0]  v;
        logic [4:0]  inc;
        logic        r;
        int pend [5];
        tick('0, '0, '0, 1'b1);
        for (int o = 0; o < 5; o++) pend[o] = 0;
        for (int c = 0; c < 400; c++) begin
            d[31:0]  = $urandom();
            d[63:32] = $urandom();
            d[79:64] = 16'($urandom());
            v = 5'($urandom_range(0, 31));
            r = (c == 200);
            inc = '0;
            for (int o = 0; o < 5; o++) begin
                if (pend[o] > 0 && $urandom_range(0, 2) != 0) begin
                    inc[o] = 1'b1;
                    pend[o]--;
                end
            end
            tick(v, d, inc, r);
            if (r) for (int o = 0; o < 5; o++) pend[o] = 0;
            for (int o = 0; o < 5; o++) if (exp_valid[o]) pend[o]++;
            vectors++;
            if (valid_o !== exp_valid || incr_o !== exp_incr || err_o !== exp_err ||
                (data_o & lane_mask(exp_valid)) !== (exp_data & lane_mask(exp_valid))) begin
                miscompares++;
                $display("FAIL random c%0d: valid %b/%b incr %b/%b err %b/%b data %h/%h", c,
                         valid_o, exp_valid, incr_o, exp_incr, err_o, exp_err, data_o, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_local_arbitration();
        test_credit_stall();
        test_fifo_overflow();
        test_reset_mid();
        test_credit_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
